// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO burst reader.
// Holds the reader FSM state enum, FIFO read latency and buffer depth.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } rd_state_e;

   localparam int RD_LATENCY = 1;
   localparam int BUF_DEPTH  = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry register FIFO of {last, data}, head in entry 0.
// Ports: clk_i/rst_i, push_i/push_data_i/push_last_i write side,
//        pop_i read side, head_data_o/head_last_o head entry, cnt_o fill.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             push_last_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_data_o,
   output logic             head_last_o,
   output logic [1:0]       cnt_o
);

   logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
   logic             l0_q, l0_d, l1_q, l1_d;
   logic [1:0]       cnt_q, cnt_d;

   always_comb begin
      d0_d  = d0_q;
      d1_d  = d1_q;
      l0_d  = l0_q;
      l1_d  = l1_q;
      cnt_d = cnt_q;
      unique case ({push_i, pop_i})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               d0_d = push_data_i;
               l0_d = push_last_i;
            end else begin
               d1_d = push_data_i;
               l1_d = push_last_i;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            d0_d  = d1_q;
            l0_d  = l1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; the new word lands behind the survivor.
            if (cnt_q == 2'd1) begin
               d0_d = push_data_i;
               l0_d = push_last_i;
            end else begin
               d0_d = d1_q;
               l0_d = l1_q;
               d1_d = push_data_i;
               l1_d = push_last_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         d0_q  <= '0;
         d1_q  <= '0;
         l0_q  <= 1'b0;
         l1_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         d0_q  <= d0_d;
         d1_q  <= d1_d;
         l0_q  <= l0_d;
         l1_q  <= l1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_data_o = d0_q;
   assign head_last_o = l0_q;
   assign cnt_o       = cnt_q;

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && !pop_i && cnt_q == 2'(BUF_DEPTH)));

   a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop_i && cnt_q == 2'd0));

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops i_len words from a sync FIFO and streams them
// out on valid/ready with o_last on the final word and an o_done pulse.
// Ports: i_clk/arst; i_start/i_len command; o_busy/o_done status;
//        o_rd_en/i_rd_data/i_empty FIFO side; o_valid/o_data/o_last/i_ready out.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LEN_W = 16
) (
   input  logic             i_clk,
   input  logic             arst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_rd_en,
   input  logic [WIDTH-1:0] i_rd_data,
   input  logic             i_empty,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_last,
   input  logic             i_ready
);

   localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

   rd_state_e        state_q, state_d;
   logic [LEN_W-1:0] issue_rem_q, issue_rem_d;
   logic [LEN_W-1:0] out_rem_q, out_rem_d;
   logic             inflight_q;
   logic             inflight_last_q;

   logic             pop;
   logic [1:0]       buf_cnt;
   logic [2:0]       credit_used;
   logic [WIDTH-1:0] head_data;
   logic             head_last;

   assign o_valid = (buf_cnt != 2'd0);
   assign pop     = o_valid && i_ready;

   // Words that will occupy the buffer after this edge if nothing new issues.
   assign credit_used = 3'(inflight_q) + 3'(buf_cnt) - 3'(pop);

   assign o_rd_en = (state_q == READ) && !i_empty &&
                    (issue_rem_q != '0) && (credit_used < CREDIT);

   assign o_busy = (state_q != IDLE);
   assign o_done = (state_q == DONE);
   assign o_data = head_data;
   assign o_last = head_last && o_valid;

   always_comb begin
      state_d     = state_q;
      issue_rem_d = issue_rem_q;
      out_rem_d   = out_rem_q;
      if (o_rd_en) begin
         issue_rem_d = issue_rem_q - LEN_W'(1);
      end
      if (pop) begin
         out_rem_d = out_rem_q - LEN_W'(1);
      end
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               if (i_len != '0) begin
                  state_d     = READ;
                  issue_rem_d = i_len;
                  out_rem_d   = i_len;
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            if (issue_rem_d == '0) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && out_rem_q == LEN_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge arst) begin
      if (arst) begin
         state_q         <= IDLE;
         issue_rem_q     <= '0;
         out_rem_q       <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         issue_rem_q     <= issue_rem_d;
         out_rem_q       <= out_rem_d;
         inflight_q      <= o_rd_en;
         // The read that empties issue_rem fetches the final word.
         inflight_last_q <= o_rd_en && (issue_rem_q == LEN_W'(1));
      end
   end

   rd_skid_buf #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk_i       (i_clk),
      .rst_i       (arst),
      .push_i      (inflight_q),
      .push_data_i (i_rd_data),
      .push_last_i (inflight_last_q),
      .pop_i       (pop),
      .head_data_o (head_data),
      .head_last_o (head_last),
      .cnt_o       (buf_cnt)
   );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench with a behavioural FIFO model.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_fifo_burst_reader;

   localparam int WIDTH = 32;
   localparam int LEN_W = 16;

   logic             i_clk = 1'b0;
   logic             arst = 1'b1;
   logic             i_start = 1'b0;
   logic [LEN_W-1:0] i_len = '0;
   logic             o_busy, o_done, o_rd_en;
   logic [WIDTH-1:0] i_rd_data = '0;
   logic             i_empty;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_last;
   logic             i_ready = 1'b0;

   fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .i_clk     (i_clk),
      .arst      (arst),
      .i_start   (i_start),
      .i_len     (i_len),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_rd_en   (o_rd_en),
      .i_rd_data (i_rd_data),
      .i_empty   (i_empty),
      .o_valid   (o_valid),
      .o_data    (o_data),
      .o_last    (o_last),
      .i_ready   (i_ready)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(bit ok, string nm, longint act, longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endfunction

   // Behavioural FIFO: 1-cycle read latency, empty when pointers meet.
   logic [WIDTH-1:0] mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign i_empty = (wr_ptr == rd_ptr);

   always @(posedge i_clk) begin
      if (o_rd_en) begin
         chk(rd_ptr != wr_ptr, "fifo_underflow", rd_ptr, wr_ptr);
         i_rd_data <= mem[rd_ptr % 1024];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Every word written to the FIFO is expected out in order.
   logic [WIDTH-1:0] expq [$];

   task automatic push_word(input logic [WIDTH-1:0] d);
      mem[wr_ptr % 1024] = d;
      wr_ptr = wr_ptr + 1;
      expq.push_back(d);
   endtask

   // Downstream ready driver.
   int rmode = 0;
   int rpat  = 0;
   int PAT [6] = '{1, 0, 0, 1, 0, 1};

   always @(posedge i_clk) begin
      #1;
      case (rmode)
         0: i_ready = 1'b1;
         1: begin
            i_ready = (PAT[rpat] != 0);
            rpat    = (rpat + 1) % 6;
         end
         2: i_ready = ($urandom_range(0, 3) != 0);
         default: i_ready = ($urandom_range(0, 1) != 0);
      endcase
   end

   // Per-burst monitor state.
   int hs_b, rd_b, done_b, cur_len, s0;
   int first_rd, last_rd, first_v, done_rel;
   int busy_cnt, busy_first, busy_last;
   bit prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic prev_last;

   always @(negedge i_clk) begin
      int rel;
      logic [WIDTH-1:0] ew;
      if (!arst) begin
         rel = cyc - s0;
         if (prev_stall) begin
            chk(o_valid, "hold_valid", o_valid, 1);
            chk(o_data == prev_data, "hold_data", o_data, prev_data);
            chk(o_last == prev_last, "hold_last", o_last, prev_last);
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         prev_last  = o_last;
         if (o_rd_en) begin
            rd_b++;
            if (first_rd < 0) first_rd = rel;
            last_rd = rel;
            chk(!i_empty, "rd_when_empty", i_empty, 0);
         end
         if (o_valid && first_v < 0) first_v = rel;
         if (o_busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
         end
         if (o_valid && i_ready) begin
            if (expq.size() == 0) begin
               chk(1'b0, "unexpected_word", o_data, 0);
            end else begin
               ew = expq.pop_front();
               chk(o_data == ew, "data", o_data, ew);
               chk(o_last == (hs_b == cur_len - 1), "last",
                   o_last, (hs_b == cur_len - 1));
            end
            hs_b++;
         end
         if (o_busy) chk(rd_b - hs_b <= 2, "credit", rd_b - hs_b, 2);
         if (o_done) begin
            done_b++;
            done_rel = rel;
            chk(hs_b == cur_len, "done_after_last", hs_b, cur_len);
         end
      end
   end

   task automatic clk1();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_burst(input int len);
      hs_b = 0; rd_b = 0; done_b = 0; cur_len = len;
      first_rd = -1; last_rd = -1; first_v = -1; done_rel = -1;
      busy_cnt = 0; busy_first = -1; busy_last = -1;
      i_start = 1'b1;
      i_len   = LEN_W'(len);
      s0      = cyc;
      clk1();
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int len);
      int t;
      t = 0;
      while (done_b == 0 && t < 2000) begin
         clk1();
         t++;
      end
      chk(done_b != 0, {nm, "_done_seen"}, done_b, 1);
      repeat (3) clk1();
      chk(done_b == 1, {nm, "_one_done"}, done_b, 1);
      chk(hs_b == len, {nm, "_words"}, hs_b, len);
      chk(rd_b == len, {nm, "_reads"}, rd_b, len);
      chk(!o_busy, {nm, "_idle"}, o_busy, 0);
   endtask

   task automatic chk_zero(input string nm);
      chk(!o_busy, {nm, "_busy"}, o_busy, 0);
      chk(!o_done, {nm, "_done"}, o_done, 0);
      chk(!o_rd_en, {nm, "_rd_en"}, o_rd_en, 0);
      chk(!o_valid, {nm, "_valid"}, o_valid, 0);
      chk(o_data == '0, {nm, "_data"}, o_data, 0);
      chk(!o_last, {nm, "_last"}, o_last, 0);
   endtask

   initial begin
      int t, n, len, pre;
      repeat (3) clk1();
      chk_zero("reset");
      arst = 1'b0;
      clk1();

      // Basic 8-word burst with exact cycle timing.
      rmode = 0;
      for (int i = 0; i < 8; i++) push_word(WIDTH'(32'hA0 + i));
      start_burst(8);
      wait_done("basic", 8);
      chk(first_rd == 1, "basic_first_rd", first_rd, 1);
      chk(last_rd == 8, "basic_last_rd", last_rd, 8);
      chk(first_v == 3, "basic_first_valid", first_v, 3);
      chk(done_rel == 11, "basic_done_cycle", done_rel, 11);
      chk(busy_first == 1, "basic_busy_first", busy_first, 1);
      chk(busy_last == 11, "basic_busy_last", busy_last, 11);
      chk(busy_cnt == 11, "basic_busy_cnt", busy_cnt, 11);

      // Zero length.
      start_burst(0);
      wait_done("zero", 0);
      chk(first_rd == -1, "zero_no_rd", first_rd, -1);
      chk(first_v == -1, "zero_no_valid", first_v, -1);
      chk(done_rel == 1, "zero_done_cycle", done_rel, 1);
      chk(busy_cnt == 1, "zero_busy_cnt", busy_cnt, 1);

      // Backpressure pattern 1,0,0,1,0,1.
      rmode = 1;
      rpat  = 0;
      for (int i = 0; i < 5; i++) push_word(WIDTH'(32'h10 + i));
      start_burst(5);
      wait_done("bp", 5);
      rmode = 0;

      // Empty stall, refill after 20 cycles.
      push_word($urandom);
      push_word($urandom);
      start_burst(4);
      repeat (20) clk1();
      chk(hs_b == 2, "stall_words", hs_b, 2);
      chk(o_busy, "stall_busy", o_busy, 1);
      push_word($urandom);
      push_word($urandom);
      wait_done("stall", 4);

      // Start while busy is ignored.
      for (int i = 0; i < 13; i++) push_word($urandom);
      start_burst(6);
      repeat (3) clk1();
      i_start = 1'b1;
      i_len   = LEN_W'(7);
      clk1();
      i_start = 1'b0;
      wait_done("busy_start", 6);
      start_burst(7);
      wait_done("drain7", 7);

      // Reset after the 4th handshake.
      for (int i = 0; i < 10; i++) push_word($urandom);
      start_burst(10);
      t = 0;
      while (hs_b < 4 && t < 200) begin
         clk1();
         t++;
      end
      chk(hs_b >= 4, "rst_reach4", hs_b, 4);
      arst = 1'b1;
      #1;
      chk_zero("midrst");
      chk(done_b == 0, "rst_no_done", done_b, 0);
      prev_stall = 1'b0;
      clk1();
      clk1();
      arst = 1'b0;
      expq.delete();
      for (int p = rd_ptr; p < wr_ptr; p++) expq.push_back(mem[p % 1024]);
      clk1();
      chk(done_b == 0, "rst_no_done_after", done_b, 0);
      start_burst(3);
      wait_done("after_rst", 3);
      n = wr_ptr - rd_ptr;
      if (n > 0) begin
         start_burst(n);
         wait_done("rst_leftover", n);
      end

      // Randomised bursts with partial preload and random backpressure.
      for (int b = 0; b < 12; b++) begin
         rmode = 2 + (b % 2);
         len   = $urandom_range(1, 12);
         pre   = $urandom_range(0, len);
         for (int i = 0; i < pre; i++) push_word($urandom);
         start_burst(len);
         for (int i = pre; i < len; i++) begin
            repeat ($urandom_range(0, 4)) clk1();
            push_word($urandom);
         end
         wait_done("rand", len);
      end
      rmode = 0;
      chk(expq.size() == 0, "final_queue_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
